serial_scan_ctrl: RTL and testbench
===================================

Name: serial_scan_ctrl

Overview:
Controller that accepts parallel words over a valid/ready handshake and serialises each word MSB-first into a shared serial pattern detector. It counts overlapping pattern hits per word and reports the count with a one-cycle done pulse. It sits between a parallel producer and the bit-serial detection datapath, and it owns sequencing, detector history and result reporting.

Parameters:
WORD_W, 16, bits per input word (>= PAT_LEN)
PAT_LEN, 5, pattern length in bits (2..8)
PATTERN, 5'b10010, pattern to detect; its first bit is the oldest
CNT_W, $clog2(WORD_W+1), width of match_count

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a word
in_word  input  WORD_W  word to scan, MSB shifted first
in_ready  output  1  controller can accept a word
busy  output  1  high while shifting
bit_out  output  1  bit currently presented to the detector
done  output  1  one-cycle pulse: match_count final
match_count  output  CNT_W  overlapping hits in last word

Behaviour:
- Reset (async, Reset high) puts the block in IDLE and sets outputs to: in_ready=1, busy=0, done=0, bit_out=0, match_count=0. It also clears detector history and the fill counter.
- FSM states are IDLE, SHIFT and DONE. The default/illegal encoding goes to IDLE.
- in_ready=1 in IDLE and DONE and 0 in SHIFT. Acceptance is in_valid && in_ready at a rising edge.
- On acceptance:
  - latch in_word into the shift register
  - clear match_count
  - load bit index WORD_W-1
  - go to SHIFT.
- SHIFT lasts exactly WORD_W cycles. Each cycle:
  - bit_out = current MSB of the shift register
  - the detector evaluates {hist[PAT_LEN-2:0], bit_out} == PATTERN, gated by fill >= PAT_LEN-1
  - match_count increments in the same cycle on a hit, saturating at all-ones
  - hist shifts bit_out in
  - fill increments, saturating at PAT_LEN-1.
- Matches overlap. After a hit, history is kept and the next hit can share bits with the previous one.
- After the last bit, go to DONE. DONE lasts one cycle with done=1.
- match_count is stable from the DONE cycle until the next acceptance.
- Latency: acceptance at edge t gives done high during cycle t+WORD_W+1.
- Acceptance in DONE goes straight to SHIFT, so back-to-back words have a period of WORD_W+1 cycles.
- in_valid is ignored while in SHIFT. in_word only needs to be stable at the acceptance edge.
- busy=1 exactly in SHIFT.
- bit_out=0 outside SHIFT.
- Without the optional feature, hist and fill clear on every acceptance, so no hit spans two words.
- Reset mid-SHIFT aborts the word immediately. No done is produced for it, and the next word is scanned from clean history.

Optional Feature:
Macro SCAN_CARRY_EN.
- Defined: hist and fill are not cleared on acceptance. Detector history carries across consecutive words, so a hit can complete in the first bits of a new word and counts toward the new word. Only Reset clears history.
- Undefined: history clears on each acceptance, as described above.

Decomposition:
- Package scan_pkg holds:
  - the state enum typedef (IDLE/SHIFT/DONE)
  - default PATTERN and PAT_LEN localparams
  - a function computing CNT_W.
- Sub-module pattern_match holds hist, the fill counter and the combinational hit output. Its ports are:
  - Clock, Reset
  - bit_in, bit_en
  - clr (tied off under SCAN_CARRY_EN)
  - hit.
- The controller holds the FSM, shift register, bit index and counter.

Test Plan:
- Reset, then in_word=16'h9249 (bits 1001001001001001) accepted at edge t -> busy for 16 cycles, done pulse at cycle t+17, match_count=4.
- Words 16'h0000 then 16'hFFFF -> match_count=0 for each, done every 17 cycles.
- 16'h0009 then 16'h0000, back-to-back -> without SCAN_CARRY_EN counts are 0 and 0; with it, counts are 0 and 1 (hit on the first bit of word 2).
- in_valid held high with a new in_word each cycle during SHIFT -> no acceptance until DONE; in_ready is 0 for exactly 16 cycles per word.
- Reset pulsed after 8 bits of 16'h9249 -> next cycle in_ready=1, match_count=0, no done; rescan of 16'h9249 gives 4.
- WORD_W=8, PATTERN=5'b10010, in_word=8'h92 (10010010) -> match_count=2 (overlapping), done at t+9.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and defaults for the serial scan controller.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_e;

    localparam int unsigned DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b10010;

    // Width needed to hold a hit count of 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/pattern_match.sv
// Bit-serial overlapping pattern detector: keeps the last PAT_LEN-1 bits
// and a fill counter so no hit is reported before enough history exists.
module pattern_match
    import scan_pkg::*;
#(
    parameter int unsigned             PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]      PATTERN = DEF_PATTERN
) (
    input  logic Clock,
    input  logic Reset,
    input  logic bit_in,
    input  logic bit_en,
    input  logic clr,
    output logic hit
);

    localparam int unsigned HW = PAT_LEN - 1;
    localparam int unsigned FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

    logic [HW-1:0] hist;
    logic [FW-1:0] fill;

    // History shift register and saturating fill counter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_en) begin
            hist <= HW'({hist, bit_in});
            if (fill != FILL_MAX)
                fill <= fill + FW'(1);
        end
    end

    // Hit when the incoming bit completes the pattern; history survives a hit.
    always_comb begin
        hit = bit_en && (fill == FILL_MAX) && ({hist, bit_in} == PATTERN);
    end

endmodule

// File: rtl/serial_scan_ctrl.sv
// Serialising scan controller: accepts a word over valid/ready, shifts it
// MSB-first into pattern_match and reports the per-word hit count.
// Build option: define SCAN_CARRY_EN to keep detector history across words.
module serial_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned          WORD_W  = 16,
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN,
    parameter int unsigned          CNT_W   = cnt_width(WORD_W)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    output logic              busy,
    output logic              bit_out,
    output logic              done,
    output logic [CNT_W-1:0]  match_count
);

    localparam int unsigned IW = $clog2(WORD_W);

    scan_state_e       state, state_nxt;
    logic [WORD_W-1:0] sreg;
    logic [IW-1:0]     idx;
    logic              accept;
    logic              hit;
    logic              det_clr;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        bit_out   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                busy    = 1'b1;
                bit_out = sreg[WORD_W-1];
                if (idx == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                in_ready  = 1'b1;
                done      = 1'b1;
                state_nxt = in_valid ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = in_valid && in_ready;
    end

    // Shift register, bit index and saturating hit counter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sreg        <= '0;
            idx         <= '0;
            match_count <= '0;
        end else if (accept) begin
            sreg        <= in_word;
            idx         <= IW'(WORD_W - 1);
            match_count <= '0;
        end else if (busy) begin
            sreg <= {sreg[WORD_W-2:0], 1'b0};
            idx  <= idx - IW'(1);
            if (hit && (match_count != '1))
                match_count <= match_count + CNT_W'(1);
        end
    end

`ifdef SCAN_CARRY_EN
    assign det_clr = 1'b0;
`else
    assign det_clr = accept;
`endif

    pattern_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_match (
        .Clock  (Clock),
        .Reset  (Reset),
        .bit_in (bit_out),
        .bit_en (busy),
        .clr    (det_clr),
        .hit    (hit)
    );

endmodule

// File: tb/tb_serial_scan_ctrl.sv
// Directed self-checking bench for serial_scan_ctrl (16-bit and 8-bit builds).
module tb_serial_scan_ctrl;

    localparam int unsigned WA = 16;
    localparam int unsigned WB = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    logic          a_valid = 1'b0;
    logic [WA-1:0] a_word  = '0;
    logic          a_ready, a_busy, a_bit, a_done;
    logic [4:0]    a_cnt;

    logic          b_valid = 1'b0;
    logic [WB-1:0] b_word  = '0;
    logic          b_ready, b_busy, b_bit, b_done;
    logic [3:0]    b_cnt;

    int checks = 0;
    int errors = 0;

    serial_scan_ctrl #(
        .WORD_W (WA)
    ) dut_a (
        .Clock       (Clock),
        .Reset       (Reset),
        .in_valid    (a_valid),
        .in_word     (a_word),
        .in_ready    (a_ready),
        .busy        (a_busy),
        .bit_out     (a_bit),
        .done        (a_done),
        .match_count (a_cnt)
    );

    serial_scan_ctrl #(
        .WORD_W  (WB),
        .PAT_LEN (5),
        .PATTERN (5'b10010)
    ) dut_b (
        .Clock       (Clock),
        .Reset       (Reset),
        .in_valid    (b_valid),
        .in_word     (b_word),
        .in_ready    (b_ready),
        .busy        (b_busy),
        .bit_out     (b_bit),
        .done        (b_done),
        .match_count (b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Offer one word to dut_a, then watch the whole scan through the DONE cycle.
    // Returns while dut_a sits in DONE, so a following call is back-to-back.
    task automatic run_word(input string tag, input logic [WA-1:0] w,
                            input int exp_cnt, input bit hold);
        int waited   = 0;
        int ready_lo = 0;
        int busy_n   = 0;
        int done_n   = 0;
        int done_at  = 0;
        logic [WA-1:0] ser = '0;
        a_valid = 1'b1;
        a_word  = w;
        while (!a_ready && waited < 50) begin
            tick();
            waited++;
        end
        check_eq({tag, "_wait"}, waited, 0);
        tick();
        if (!hold)
            a_valid = 1'b0;
        for (int c = 1; c <= WA + 1; c++) begin
            if (!a_ready)
                ready_lo++;
            if (a_busy) begin
                busy_n++;
                ser = {ser[WA-2:0], a_bit};
            end
            if (a_done) begin
                done_n++;
                if (done_at == 0)
                    done_at = c;
            end
            if (hold)
                a_word = WA'($urandom);
            if (c <= WA)
                tick();
        end
        a_valid = 1'b0;
        check_eq({tag, "_done_at"}, done_at, WA + 1);
        check_eq({tag, "_done_n"}, done_n, 1);
        check_eq({tag, "_ready_lo"}, ready_lo, WA);
        check_eq({tag, "_busy_n"}, busy_n, WA);
        check_eq({tag, "_serial"}, ser, w);
        check_eq({tag, "_bit_idle"}, a_bit, 1'b0);
        check_eq({tag, "_count"}, a_cnt, exp_cnt);
    endtask

    initial begin : stim
        int dn;
        int done_at;
        int carry_exp;

        // Reset values while Reset is held.
        #3;
        check_eq("rst_ready", a_ready, 1'b1);
        check_eq("rst_busy", a_busy, 1'b0);
        check_eq("rst_done", a_done, 1'b0);
        check_eq("rst_bit", a_bit, 1'b0);
        check_eq("rst_cnt", a_cnt, 0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // Overlapping hits in 1001001001001001.
        run_word("w9249", 16'h9249, 4, 1'b0);
        tick();

        // No hits, back-to-back.
        run_word("w0000", 16'h0000, 0, 1'b0);
        run_word("wFFFF", 16'hFFFF, 0, 1'b0);
        tick();
        tick();

        // Cross-word hit only when history carries.
`ifdef SCAN_CARRY_EN
        carry_exp = 1;
`else
        carry_exp = 0;
`endif
        run_word("w0009", 16'h0009, 0, 1'b0);
        run_word("w0000b", 16'h0000, carry_exp, 1'b0);
        tick();

        // in_valid held with changing in_word during SHIFT.
        run_word("hold", 16'h9249, 4, 1'b1);
        tick();
        tick();

        // Reset after 8 bits of 16'h9249 (1001_0010 -> two hits so far).
        a_valid = 1'b1;
        a_word  = 16'h9249;
        tick();
        a_valid = 1'b0;
        repeat (8) tick();
        check_eq("mid_cnt", a_cnt, 2);
        check_eq("mid_busy", a_busy, 1'b1);
        #1 Reset = 1'b1;
        #1 Reset = 1'b0;
        check_eq("abort_ready", a_ready, 1'b1);
        check_eq("abort_busy", a_busy, 1'b0);
        check_eq("abort_cnt", a_cnt, 0);
        check_eq("abort_done", a_done, 1'b0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_done)
                dn++;
            tick();
        end
        check_eq("abort_no_done", dn, 0);
        run_word("rescan", 16'h9249, 4, 1'b0);
        tick();

        // 8-bit instance: 10010010 -> 2 overlapping hits, done at t+9.
        b_valid = 1'b1;
        b_word  = 8'h92;
        check_eq("b_ready", b_ready, 1'b1);
        tick();
        b_valid = 1'b0;
        done_at = 0;
        dn = 0;
        for (int c = 1; c <= 20; c++) begin
            if (b_done) begin
                dn++;
                if (done_at == 0)
                    done_at = c;
            end
            if (b_done)
                check_eq("b_count", b_cnt, 2);
            tick();
        end
        check_eq("b_done_at", done_at, WB + 1);
        check_eq("b_done_n", dn, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
